// File: rtl/demux32_1_2.sv
// ----------------------------------------------------------------------------
// demux32_1_2
//
// Registered 1-to-2 stream demultiplexer. Each input word is steered by `sel`
// into one of two independent output FIFOs (DEPTH entries each). The producer
// only stalls when the FIFO it is currently addressing is full, so a stalled
// consumer never blocks traffic destined for the other consumer.
//
// Parameters:
//   WIDTH  data word width
//   DEPTH  entries per output FIFO (power of two, >= 2)
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-high reset (flushes both FIFOs)
//   in_valid/in_ready    input handshake; word taken when both are high
//   in_data              input word
//   sel                  destination: 0 -> out1, 1 -> out2
//   out1_valid/ready     channel 1 handshake (valid = FIFO non-empty)
//   out1_data            channel 1 head word, 0 while empty
//   out2_valid/ready     channel 2 handshake
//   out2_data            channel 2 head word, 0 while empty
//   cnt1, cnt2           16-bit wrapping accepted-word counters
//
// Build option:
//   DEMUX32_CNT_EN       when defined, adds the cnt1/cnt2 ports and counters.
// ----------------------------------------------------------------------------
module demux32_1_2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data
`ifdef DEMUX32_CNT_EN
    ,
    output logic [15:0]      cnt1,
    output logic [15:0]      cnt2
`endif
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    COUNT_FULL = (AW + 1)'(DEPTH);

    // Per-channel handshake vectors: index 0 is out1, index 1 is out2.
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            full;
    logic [1:0]            not_empty;
    logic [1:0]            out_ready;
    logic [1:0][WIDTH-1:0] head;

    assign out_ready = {out2_ready, out1_ready};

    // Readiness looks only at the addressed FIFO's occupancy, never at the
    // consumer's ready, so a full FIFO does not accept a word even when it is
    // being drained in the same cycle.
    assign in_ready = sel ? !full[1] : !full[0];

    assign push[0] = in_valid && in_ready && !sel;
    assign push[1] = in_valid && in_ready &&  sel;
    assign pop     = not_empty & out_ready;

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [AW:0]      count;
        logic [WIDTH-1:0] mem [DEPTH];

        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers are exactly AW bits wide, so they wrap for free.
                if (push[ch]) wr_ptr <= wr_ptr + 1'b1;
                if (pop[ch])  rd_ptr <= rd_ptr + 1'b1;
                case ({push[ch], pop[ch]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;  // idle, or push and pop cancel out
                endcase
            end
        end

        // NOTE: storage has no reset; the occupancy count alone decides which
        // entries are meaningful, and a resettable array would cost a reset
        // mux per bit for nothing.
        always_ff @(posedge clk) begin
            if (push[ch] && !rst) mem[wr_ptr] <= in_data;
        end

        assign full[ch]      = (count == COUNT_FULL);
        assign not_empty[ch] = (count != '0);
        assign head[ch]      = not_empty[ch] ? mem[rd_ptr] : '0;
    end

    assign out1_valid = not_empty[0];
    assign out2_valid = not_empty[1];
    assign out1_data  = head[0];
    assign out2_data  = head[1];

`ifdef DEMUX32_CNT_EN
    // Accepted-word counters: count pushes only, wrap at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1 <= '0;
            cnt2 <= '0;
        end else begin
            if (push[0]) cnt1 <= cnt1 + 16'd1;
            if (push[1]) cnt2 <= cnt2 + 16'd1;
        end
    end
`else
    // Counter option disabled: no counter registers or ports.
`endif

endmodule

// File: tb/tb_demux32_1_2.sv
`timescale 1ns/1ps
module tb_demux32_1_2;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out2_valid;
    logic             out2_ready;
    logic [WIDTH-1:0] out2_data;
`ifdef DEMUX32_CNT_EN
    logic [15:0]      cnt1;
    logic [15:0]      cnt2;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per channel plus accepted-word counters.
    logic [WIDTH-1:0] q1[$];
    logic [WIDTH-1:0] q2[$];
    int               m_cnt1 = 0;
    int               m_cnt2 = 0;
    logic [WIDTH-1:0] dut_rx2[$];

    demux32_1_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .sel        (sel),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .out2_data  (out2_data)
`ifdef DEMUX32_CNT_EN
        ,
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic bit m_ready(input logic s);
        return s ? (q2.size() != DEPTH) : (q1.size() != DEPTH);
    endfunction

    function automatic logic [WIDTH-1:0] m_head1();
        return (q1.size() != 0) ? q1[0] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_head2();
        return (q2.size() != 0) ? q2[0] : '0;
    endfunction

    // Advance one clock; the model applies the handshakes seen before the edge.
    task automatic tick();
        bit               acc, p1, p2, s;
        logic [WIDTH-1:0] d;
        acc = in_valid && m_ready(sel);
        s   = sel;
        d   = in_data;
        p1  = (q1.size() != 0) && out1_ready;
        p2  = (q2.size() != 0) && out2_ready;
        if (out2_valid && out2_ready) dut_rx2.push_back(out2_data);
        @(posedge clk);
        if (rst) begin
            q1.delete();
            q2.delete();
            m_cnt1 = 0;
            m_cnt2 = 0;
        end else begin
            if (p1) void'(q1.pop_front());
            if (p2) void'(q2.pop_front());
            if (acc) begin
                if (s) begin q2.push_back(d); m_cnt2 = (m_cnt2 + 1) % 65536; end
                else   begin q1.push_back(d); m_cnt1 = (m_cnt1 + 1) % 65536; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; sel = 1'b0; in_data = $urandom;
        out1_ready = 1'b0; out2_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0; in_valid = 1'b0; sel = 1'b0;
        #1;
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid got %b exp 0", out1_valid); end
        checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL reset_out2_valid got %b exp 0", out2_valid); end
        checks++; if (out1_data !== '0) begin errors++; $display("FAIL reset_out1_data got %h exp 0", out1_data); end
        checks++; if (out2_data !== '0) begin errors++; $display("FAIL reset_out2_data got %h exp 0", out2_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel0 got %b exp 1", in_ready); end
        sel = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_sel1 got %b exp 1", in_ready); end
`ifdef DEMUX32_CNT_EN
        checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %h exp 0", cnt1); end
        checks++; if (cnt2 !== 16'd0) begin errors++; $display("FAIL reset_cnt2 got %h exp 0", cnt2); end
`endif
        tick();
    endtask

    task automatic test_steering();
        out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'h1111_1111;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL steer_in_ready got %b exp 1", in_ready); end
        tick();
        sel = 1'b1; in_data = 32'h2222_2222;
        #1;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'h1111_1111) begin errors++; $display("FAIL steer_out1 got %b/%h exp 1/11111111", out1_valid, out1_data); end
        checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL steer_out2_early got %b exp 0", out2_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL steer_out1_once got %b exp 0", out1_valid); end
        checks++; if (out2_valid !== 1'b1 || out2_data !== 32'h2222_2222) begin errors++; $display("FAIL steer_out2 got %b/%h exp 1/22222222", out2_valid, out2_data); end
        tick();
        checks++; if (out2_valid !== 1'b0 || out2_data !== '0) begin errors++; $display("FAIL steer_out2_once got %b/%h exp 0/0", out2_valid, out2_data); end
    endtask

    task automatic test_full_backpressure();
        out1_ready = 1'b0; out2_ready = 1'b0;
        in_valid = 1'b1; sel = 1'b0; in_data = 32'hA0;
        tick();
        in_data = 32'hA1;
        tick();
        in_data = 32'hA2;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        tick();
        sel = 1'b1; in_data = 32'hB0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_other_ready got %b exp 1", in_ready); end
        tick();
        in_valid = 1'b0; sel = 1'b0; out1_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_no_passthru got %b exp 0", in_ready); end
        checks++; if (out1_data !== 32'hA0) begin errors++; $display("FAIL full_head0 got %h exp 000000a0", out1_data); end
        checks++; if (out2_valid !== 1'b1 || out2_data !== 32'hB0) begin errors++; $display("FAIL full_out2 got %b/%h exp 1/000000b0", out2_valid, out2_data); end
        tick();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hA1) begin errors++; $display("FAIL full_head1 got %b/%h exp 1/000000a1", out1_valid, out1_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", in_ready); end
        tick();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", out1_valid); end
        out2_ready = 1'b1;
        tick();
        checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL full_out2_drained got %b exp 0", out2_valid); end
        out2_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        out1_ready = 1'b0; in_valid = 1'b1; sel = 1'b0; in_data = 32'hBF;
        tick();
        in_data = 32'hC0; out1_ready = 1'b1;
        #1;
        checks++; if (out1_data !== 32'hBF) begin errors++; $display("FAIL simul_old_head got %h exp 000000bf", out1_data); end
        tick();
        in_valid = 1'b0; sel = 1'b1;
        checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hC0) begin errors++; $display("FAIL simul_new_head got %b/%h exp 1/000000c0", out1_valid, out1_data); end
        sel = 1'b0;
        #1;
        // One entry held means one free slot, so the input is still open.
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL simul_count_one got %b exp 1", in_ready); end
        tick();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL simul_empty got %b exp 0", out1_valid); end
    endtask

    task automatic test_wrap();
        int idx = 0;
        int cyc = 0;
        dut_rx2.delete();
        out1_ready = 1'b1; sel = 1'b1;
        while (dut_rx2.size() < 9 && cyc < 100) begin
            out2_ready = (cyc % 2 == 0);
            in_valid   = (idx < 9);
            in_data    = idx;
            #1;
            if (in_valid && (in_ready !== m_ready(sel))) begin
                checks++; errors++;
                $display("FAIL wrap_in_ready cycle %0d got %b exp %b", cyc, in_ready, m_ready(sel));
            end
            if (in_valid && m_ready(sel)) idx++;
            tick();
            cyc++;
        end
        in_valid = 1'b0; out2_ready = 1'b0;
        checks++; if (dut_rx2.size() != 9) begin errors++; $display("FAIL wrap_count got %0d exp 9", dut_rx2.size()); end
        for (int i = 0; i < dut_rx2.size() && i < 9; i++) begin
            checks++;
            if (dut_rx2[i] !== WIDTH'(i)) begin errors++; $display("FAIL wrap_word%0d got %h exp %h", i, dut_rx2[i], WIDTH'(i)); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            sel        = 1'($urandom);
            in_data    = $urandom;
            out1_ready = 1'($urandom);
            out2_ready = 1'($urandom);
            #1;
            checks++; if (in_ready !== m_ready(sel)) begin errors++; $display("FAIL rand_in_ready i=%0d got %b exp %b", i, in_ready, m_ready(sel)); end
            checks++; if (out1_valid !== (q1.size() != 0) || out1_data !== m_head1()) begin errors++; $display("FAIL rand_out1 i=%0d got %b/%h exp %b/%h", i, out1_valid, out1_data, q1.size() != 0, m_head1()); end
            checks++; if (out2_valid !== (q2.size() != 0) || out2_data !== m_head2()) begin errors++; $display("FAIL rand_out2 i=%0d got %b/%h exp %b/%h", i, out2_valid, out2_data, q2.size() != 0, m_head2()); end
`ifdef DEMUX32_CNT_EN
            checks++; if (cnt1 !== 16'(m_cnt1) || cnt2 !== 16'(m_cnt2)) begin errors++; $display("FAIL rand_cnt i=%0d got %h/%h exp %h/%h", i, cnt1, cnt2, 16'(m_cnt1), 16'(m_cnt2)); end
`endif
            tick();
        end
        in_valid = 1'b0; out1_ready = 1'b1; out2_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
`ifdef DEMUX32_CNT_EN
        in_valid = 1'b1; sel = 1'b0; out1_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = $urandom;
            tick();
        end
        checks++; if (cnt1 !== 16'hFFFF || cnt1 !== 16'(m_cnt1)) begin errors++; $display("FAIL cnt_preload got %h exp ffff", cnt1); end
        in_data = $urandom;
        tick();
        checks++; if (cnt1 !== 16'h0000) begin errors++; $display("FAIL cnt_wrap got %h exp 0000", cnt1); end
        checks++; if (cnt2 !== 16'h0000) begin errors++; $display("FAIL cnt2_untouched got %h exp 0000", cnt2); end
        in_valid = 1'b0;
        tick();
`endif
        out1_ready = 1'b0; in_valid = 1'b1; sel = 1'b0;
        in_data = 32'h5A5A_0001;
        tick();
        in_data = 32'h5A5A_0002;
        tick();
        checks++; if (out1_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_two_held got %b/%b exp 1/0", out1_valid, in_ready); end
        sel = 1'b1; in_data = 32'hDEAD_BEEF; rst = 1'b1; out1_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin errors++; $display("FAIL mid_flush got %b/%b exp 0/0", out1_valid, out2_valid); end
        checks++; if (out1_data !== '0 || out2_data !== '0) begin errors++; $display("FAIL mid_flush_data got %h/%h exp 0/0", out1_data, out2_data); end
`ifdef DEMUX32_CNT_EN
        checks++; if (cnt1 !== 16'd0 || cnt2 !== 16'd0) begin errors++; $display("FAIL mid_cnt got %h/%h exp 0/0", cnt1, cnt2); end
`endif
        tick();
        checks++; if (out2_valid !== 1'b0) begin errors++; $display("FAIL mid_no_store got %b exp 0", out2_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        test_reset();
        test_steering();
        test_full_backpressure();
        test_simultaneous();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
